corefifo_ptr_sync_level: RTL and testbench
==========================================

Name: corefifo_ptr_sync_level

Overview:
Parametrised clock-domain-crossing pointer synchroniser for the dual-clock FIFO.
- Carries a gray-coded pointer from the far domain through a configurable N-flop chain.
- Converts it to binary and flags illegal multi-bit gray transitions.
- Computes registered FIFO occupancy and the full/empty and threshold flags against the local binary pointer.
- One instance sits on the write side (remote read pointer) and one on the read side (remote write pointer).

Parameters:
ADDRWIDTH, 3, FIFO address width; pointers are ADDRWIDTH+1 bits; DEPTH = 2**ADDRWIDTH.
SYNC_STAGES, 2, synchroniser flop count; legal 2..4; any other value is an elaboration error.
MODE, 0, 0 = write side (local wptr, remote rptr, full flag); 1 = read side (local rptr, remote wptr, empty flag).
THRESH, 6, threshold level for thr_flag; legal 0..DEPTH.

Ports:
clk  in  1  local-domain clock
rstn  in  1  reset, asynchronous, active-low
gray_in  in  ADDRWIDTH+1  gray-coded pointer from far domain (unsynchronised)
local_ptr  in  ADDRWIDTH+1  binary pointer of local domain
sync_gray_out  out  ADDRWIDTH+1  last synchroniser stage
sync_bin_out  out  ADDRWIDTH+1  registered binary of synchronised pointer
ptr_upd  out  1  one-cycle pulse: synchronised pointer changed
gray_err  out  1  one-cycle pulse: >1 bit changed between consecutive synchronised samples
level  out  ADDRWIDTH+1  registered occupancy
flag  out  1  MODE0: full (level==DEPTH); MODE1: empty (level==0)
thr_flag  out  1  MODE0: level>=THRESH; MODE1: level<=THRESH
level_err  out  1  sticky: computed level exceeded DEPTH

Behaviour:
Reset:
- rstn low clears every flop asynchronously, regardless of clk.
- All outputs go to 0, except: flag=1 in MODE1 (empty); thr_flag=1 in MODE1 (0<=THRESH).
- A reset mid-operation discards all in-flight samples. After release, outputs resume per the latencies below.

Stage chain:
- s[0]<=gray_in; s[k]<=s[k-1].
- sync_gray_out=s[SYNC_STAGES-1].
- Latency from gray_in to sync_gray_out is SYNC_STAGES cycles.

Stage B (one cycle after the chain):
- gray_q<=s[S-1].
- sync_bin_out<=g2b(s[S-1]), where b[MSB]=g[MSB] and b[i]=b[i+1]^g[i].
- ptr_upd<=(s[S-1]!=gray_q).
- gray_err<=(popcount(s[S-1]^gray_q)>1).
- Latency SYNC_STAGES+1.

Stage C (one cycle after stage B):
- lv = MODE0 ? local_ptr-sync_bin_out : sync_bin_out-local_ptr, computed modulo 2**(ADDRWIDTH+1) with natural wrap and no carry out.
- level<=lv; flag and thr_flag are registered from lv in the same cycle.
- If lv>DEPTH: level_err<=1, held until reset. level still takes lv; flags are computed from lv unmodified.
- Latency from gray_in to level is SYNC_STAGES+2. A change on local_ptr appears on level after 1 cycle.

Other rules:
- Any change on gray_in propagates even when gray_err fires; there is no filtering.
- Simultaneous change of local_ptr and a remote update: each is reflected as soon as it reaches stage C; there is no priority.
- No enable; the block runs every cycle.

Decomposition:
- Shared package corefifo_pkg:
  - function g2b
  - function popcount
  - localparams MODE_WR=0, MODE_RD=1
  - DEPTH derivation
- Sub-module corefifo_sync_chain(WIDTH, STAGES): the plain N-flop synchroniser with async active-low reset on clk/rstn. It is instantiated once.

Test Plan:
All tests use ADDRWIDTH=3, SYNC_STAGES=2.
1. Reset: rstn=0 with gray_in=4'b0110 -> all outputs 0. MODE1: flag=1, thr_flag=1. Release with gray_in=0 -> outputs unchanged.
2. MODE1, local_ptr=0, gray_in steps 0000->0001->0011->0010 on successive cycles:
   - sync_gray_out = 0001 at cycle+2.
   - sync_bin_out=1 with ptr_upd pulse at cycle+3.
   - level=1, flag 1->0 at cycle+4.
   - Final level=3, gray_err never fires.
3. gray_in jumps 0000->0101 in one cycle -> exactly one gray_err pulse at cycle+3, sync_bin_out=6, ptr_upd=1.
4. MODE0, local_ptr=8, gray_in=0 -> level=8, flag=1, thr_flag=1. Then gray_in=0001 -> level=7, flag=0 exactly 4 cycles later.
5. Wrap and error:
   - MODE1, local_ptr=15, remote bin 1 (gray 0001) -> level=2, no level_err.
   - Then MODE0, local_ptr=10, remote 0 -> level=10, level_err=1, stays 1 until rstn low.
6. Reset mid-operation: MODE1 with level=5, assert rstn asynchronously between clk edges -> all outputs clear immediately. After release with gray_in=0101 and local_ptr=0 -> level=6 four cycles after the first clk edge.

Source files
------------

// File: rtl/corefifo_ptr_sync_level_pkg.sv
// Shared helpers for the dual-clock FIFO pointer synchronisers:
// gray/binary conversion, bit counting and side selection constants.
package corefifo_pkg;

  localparam int MODE_WR = 0;
  localparam int MODE_RD = 1;

  // Helpers operate on a fixed wide vector; callers zero-extend and truncate.
  localparam int FN_W = 32;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic logic [FN_W-1:0] g2b(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int popcount(input logic [FN_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < FN_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/corefifo_ptr_sync_level_if.sv
// Pointer and status bundle between a FIFO side controller and its
// pointer synchroniser.
interface corefifo_ptr_sync_level_if #(
  parameter int ADDRWIDTH = 3
);

  localparam int PW = ADDRWIDTH + 1;

  logic [PW-1:0] gray_in;
  logic [PW-1:0] local_ptr;
  logic [PW-1:0] sync_gray_out;
  logic [PW-1:0] sync_bin_out;
  logic          ptr_upd;
  logic          gray_err;
  logic [PW-1:0] level;
  logic          flag;
  logic          thr_flag;
  logic          level_err;

  modport master (
    output gray_in, local_ptr,
    input  sync_gray_out, sync_bin_out, ptr_upd, gray_err,
    input  level, flag, thr_flag, level_err
  );

  modport slave (
    input  gray_in, local_ptr,
    output sync_gray_out, sync_bin_out, ptr_upd, gray_err,
    output level, flag, thr_flag, level_err
  );

endinterface

// File: rtl/corefifo_ptr_sync_level_sync_chain.sv
// Plain multi-flop synchroniser for a gray-coded pointer crossing into clk.
module corefifo_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/corefifo_ptr_sync_level.sv
// Remote pointer synchroniser plus registered occupancy and full/empty and
// threshold flags for one side of the dual-clock FIFO.
module corefifo_ptr_sync_level
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int THRESH      = 6
) (
  input logic                      clk,
  input logic                      rstn,
  corefifo_ptr_sync_level_if.slave bus
);

  localparam int PW    = ADDRWIDTH + 1;
  localparam int DEPTH = depth_of(ADDRWIDTH);

  localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
  localparam logic [PW-1:0] THRESH_V = PW'(THRESH);
  localparam logic          RST_RD   = (MODE == MODE_RD);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("corefifo_ptr_sync_level: SYNC_STAGES must be 2..4");
  end
  if (MODE != MODE_WR && MODE != MODE_RD) begin : g_bad_mode
    $error("corefifo_ptr_sync_level: MODE must be 0 or 1");
  end
  if (THRESH < 0 || THRESH > DEPTH) begin : g_bad_thresh
    $error("corefifo_ptr_sync_level: THRESH must be 0..DEPTH");
  end
  if (ADDRWIDTH < 1 || ADDRWIDTH > 30) begin : g_bad_addr
    $error("corefifo_ptr_sync_level: ADDRWIDTH must be 1..30");
  end

  logic [PW-1:0] syncGray;

  corefifo_sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (bus.gray_in),
    .q_o  (syncGray)
  );

  logic [PW-1:0] grayPrev_q;
  logic [PW-1:0] syncBin_q,  syncBin_d;
  logic          ptrUpd_q,   ptrUpd_d;
  logic          grayErr_q,  grayErr_d;
  logic [PW-1:0] level_q,    level_d;
  logic          flag_q,     flag_d;
  logic          thrFlag_q,  thrFlag_d;
  logic          levelErr_q, levelErr_d;

  // Stage B: decode the synchronised sample and compare it with the last one.
  always_comb begin
    syncBin_d = PW'(g2b(FN_W'(syncGray)));
    ptrUpd_d  = (syncGray != grayPrev_q);
    grayErr_d = (popcount(FN_W'(syncGray ^ grayPrev_q)) > 1);
  end

  // Stage C: modular pointer difference; flags use the raw difference even
  // when it is out of range so a corrupted pointer is not masked.
  always_comb begin
    level_d    = '0;
    flag_d     = 1'b0;
    thrFlag_d  = 1'b0;
    if (MODE == MODE_WR) begin
      level_d   = bus.local_ptr - syncBin_q;
      flag_d    = (level_d == DEPTH_V);
      thrFlag_d = (level_d >= THRESH_V);
    end else begin
      level_d   = syncBin_q - bus.local_ptr;
      flag_d    = (level_d == '0);
      thrFlag_d = (level_d <= THRESH_V);
    end
    levelErr_d = levelErr_q | (level_d > DEPTH_V);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grayPrev_q <= '0;
      syncBin_q  <= '0;
      ptrUpd_q   <= 1'b0;
      grayErr_q  <= 1'b0;
      level_q    <= '0;
      flag_q     <= RST_RD;
      thrFlag_q  <= RST_RD;
      levelErr_q <= 1'b0;
    end else begin
      grayPrev_q <= syncGray;
      syncBin_q  <= syncBin_d;
      ptrUpd_q   <= ptrUpd_d;
      grayErr_q  <= grayErr_d;
      level_q    <= level_d;
      flag_q     <= flag_d;
      thrFlag_q  <= thrFlag_d;
      levelErr_q <= levelErr_d;
    end
  end

  assign bus.sync_gray_out = syncGray;
  assign bus.sync_bin_out  = syncBin_q;
  assign bus.ptr_upd       = ptrUpd_q;
  assign bus.gray_err      = grayErr_q;
  assign bus.level         = level_q;
  assign bus.flag          = flag_q;
  assign bus.thr_flag      = thrFlag_q;
  assign bus.level_err     = levelErr_q;

endmodule

// File: tb/tb_corefifo_ptr_sync_level.sv
// Bench for the pointer synchroniser: a write-side and a read-side instance
// share inputs and are compared against a cycle-history model of the pipeline.
module tb_corefifo_ptr_sync_level;

  localparam int AW = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] grayDrv = '0;
  logic [3:0] lptrDrv = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  corefifo_ptr_sync_level_if #(.ADDRWIDTH(AW)) busW ();
  corefifo_ptr_sync_level_if #(.ADDRWIDTH(AW)) busR ();

  assign busW.gray_in   = grayDrv;
  assign busW.local_ptr = lptrDrv;
  assign busR.gray_in   = grayDrv;
  assign busR.local_ptr = lptrDrv;

  corefifo_ptr_sync_level #(
    .ADDRWIDTH(AW), .SYNC_STAGES(2), .MODE(0), .THRESH(6)
  ) dutW (
    .clk(clk), .rstn(rstn), .bus(busW.slave)
  );

  corefifo_ptr_sync_level #(
    .ADDRWIDTH(AW), .SYNC_STAGES(2), .MODE(1), .THRESH(6)
  ) dutR (
    .clk(clk), .rstn(rstn), .bus(busR.slave)
  );

  // gH[k] is the far pointer captured k edges ago; a reset looks like a
  // history of zero pointers.
  logic [3:0] gH [4];
  logic [3:0] lH;
  logic       lerrW, lerrR;

  function automatic logic [3:0] mG2b(input logic [3:0] g);
    logic [3:0] b;
    b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    return b;
  endfunction

  function automatic logic [3:0] mLevel(input int mode);
    logic [3:0] r;
    if (mode == 0) r = lH - mG2b(gH[3]);
    else           r = mG2b(gH[3]) - lH;
    return r;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 4; k++) gH[k] = '0;
    lH    = '0;
    lerrW = 1'b0;
    lerrR = 1'b0;
  endtask

  task automatic modelEdge();
    gH[3] = gH[2];
    gH[2] = gH[1];
    gH[1] = gH[0];
    gH[0] = grayDrv;
    lH    = lptrDrv;
    if (mLevel(0) > 4'd8) lerrW = 1'b1;
    if (mLevel(1) > 4'd8) lerrR = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) modelEdge();
    #1;
  endtask

  task automatic doReset(input logic [3:0] g, input logic [3:0] l);
    rstn = 1'b0;
    modelReset();
    grayDrv = g;
    lptrDrv = l;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] obsW, obsR;
    rstn = 1'b0;
    modelReset();
    grayDrv = 4'b0110;
    lptrDrv = '0;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 3; c++) step();
      obsW = {busW.sync_gray_out, busW.sync_bin_out, busW.ptr_upd, busW.gray_err,
              busW.level, busW.flag, busW.thr_flag, busW.level_err};
      obsR = {busR.sync_gray_out, busR.sync_bin_out, busR.ptr_upd, busR.gray_err,
              busR.level, busR.flag, busR.thr_flag, busR.level_err};
      checks += 2;
      if (obsW !== 17'h0) begin
        errors++;
        $display("[TB] FAIL reset_wr[%0d]: got %h want %h", n, obsW, 17'h0);
      end
      if (obsR !== 17'h6) begin
        errors++;
        $display("[TB] FAIL reset_rd[%0d]: got %h want %h", n, obsR, 17'h6);
      end
      grayDrv = '0;
      rstn    = 1'b1;
    end
  endtask

  task automatic test_mode1_steps();
    logic [3:0] seq [3];
    seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0010;
    doReset(4'b0000, 4'd0);
    for (int i = 0; i < 8; i++) begin
      grayDrv = (i < 3) ? seq[i] : 4'b0010;
      step();
      checks++;
      if (busR.gray_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL steps_gray_err[%0d]: got %b want 0", i + 1, busR.gray_err);
      end
      if (i + 1 == 2) begin
        checks++;
        if (busR.sync_gray_out !== 4'b0001) begin
          errors++;
          $display("[TB] FAIL steps_sync_gray: got %b want 0001", busR.sync_gray_out);
        end
      end
      if (i + 1 == 3) begin
        checks++;
        if ({busR.sync_bin_out, busR.ptr_upd} !== {4'd1, 1'b1}) begin
          errors++;
          $display("[TB] FAIL steps_bin_upd: got %h/%b want 1/1", busR.sync_bin_out, busR.ptr_upd);
        end
      end
      if (i + 1 == 4) begin
        checks++;
        if ({busR.level, busR.flag} !== {4'd1, 1'b0}) begin
          errors++;
          $display("[TB] FAIL steps_first_level: got %0d/%b want 1/0", busR.level, busR.flag);
        end
      end
    end
    checks++;
    if ({busR.level, busR.flag} !== {4'd3, 1'b0}) begin
      errors++;
      $display("[TB] FAIL steps_final_level: got %0d/%b want 3/0", busR.level, busR.flag);
    end
  endtask

  task automatic test_gray_jump();
    int pulses;
    pulses = 0;
    doReset(4'b0000, 4'd0);
    grayDrv = 4'b0101;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (busR.gray_err === 1'b1) pulses++;
      if (c == 3) begin
        checks++;
        if ({busR.gray_err, busR.sync_bin_out, busR.ptr_upd} !== {1'b1, 4'd6, 1'b1}) begin
          errors++;
          $display("[TB] FAIL jump_err_bin_upd: got %b/%0d/%b want 1/6/1",
                   busR.gray_err, busR.sync_bin_out, busR.ptr_upd);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL jump_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_full();
    doReset(4'b0000, 4'd8);
    for (int c = 0; c < 4; c++) step();
    checks++;
    if ({busW.level, busW.flag, busW.thr_flag} !== {4'd8, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL full_set: got %0d/%b/%b want 8/1/1", busW.level, busW.flag, busW.thr_flag);
    end
    grayDrv = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (c < 4) begin
        if ({busW.level, busW.flag} !== {4'd8, 1'b1}) begin
          errors++;
          $display("[TB] FAIL full_hold[%0d]: got %0d/%b want 8/1", c, busW.level, busW.flag);
        end
      end else begin
        if ({busW.level, busW.flag, busW.thr_flag} !== {4'd7, 1'b0, 1'b1}) begin
          errors++;
          $display("[TB] FAIL full_drop: got %0d/%b/%b want 7/0/1", busW.level, busW.flag, busW.thr_flag);
        end
      end
    end
  endtask

  task automatic test_wrap_err();
    doReset(4'b0001, 4'd15);
    for (int c = 0; c < 5; c++) step();
    checks++;
    if ({busR.level, busR.level_err} !== {4'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL wrap_level: got %0d/%b want 2/0", busR.level, busR.level_err);
    end
    grayDrv = 4'b0000;
    lptrDrv = 4'd10;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if ({busW.level, busW.level_err} !== {4'd10, 1'b1}) begin
      errors++;
      $display("[TB] FAIL err_set: got %0d/%b want 10/1", busW.level, busW.level_err);
    end
    lptrDrv = 4'd0;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if ({busW.level, busW.level_err} !== {4'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL err_sticky: got %0d/%b want 0/1", busW.level, busW.level_err);
    end
    #2;
    rstn = 1'b0;
    modelReset();
    #1;
    checks++;
    if (busW.level_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_cleared: got %b want 0", busW.level_err);
    end
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset_midop();
    logic [16:0] obsW, obsR;
    doReset(4'b0111, 4'd0);
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (busR.level !== 4'd5) begin
      errors++;
      $display("[TB] FAIL midop_pre_level: got %0d want 5", busR.level);
    end
    #2;
    rstn = 1'b0;
    modelReset();
    #1;
    obsW = {busW.sync_gray_out, busW.sync_bin_out, busW.ptr_upd, busW.gray_err,
            busW.level, busW.flag, busW.thr_flag, busW.level_err};
    obsR = {busR.sync_gray_out, busR.sync_bin_out, busR.ptr_upd, busR.gray_err,
            busR.level, busR.flag, busR.thr_flag, busR.level_err};
    checks += 2;
    if (obsW !== 17'h0) begin
      errors++;
      $display("[TB] FAIL midop_clear_wr: got %h want %h", obsW, 17'h0);
    end
    if (obsR !== 17'h6) begin
      errors++;
      $display("[TB] FAIL midop_clear_rd: got %h want %h", obsR, 17'h6);
    end
    grayDrv = 4'b0101;
    lptrDrv = 4'd0;
    #2;
    rstn = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 3) begin
        checks++;
        if (busR.level !== 4'd0) begin
          errors++;
          $display("[TB] FAIL midop_early_level: got %0d want 0", busR.level);
        end
      end
      if (c == 4) begin
        checks++;
        if (busR.level !== 4'd6) begin
          errors++;
          $display("[TB] FAIL midop_level: got %0d want 6", busR.level);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] expB;
    logic [6:0] expCW, expCR;
    logic [3:0] lvW, lvR;
    doReset(4'b0000, 4'd0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) grayDrv = 4'($urandom_range(0, 15));
      else                           grayDrv = grayDrv ^ 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) lptrDrv = 4'($urandom_range(0, 15));
      step();
      lvW   = mLevel(0);
      lvR   = mLevel(1);
      expB  = {gH[1], mG2b(gH[2]), gH[2] != gH[3], $countones(gH[2] ^ gH[3]) > 1};
      expCW = {lvW, lvW == 4'd8, lvW >= 4'd6, lerrW};
      expCR = {lvR, lvR == 4'd0, lvR <= 4'd6, lerrR};
      checks += 4;
      if ({busW.sync_gray_out, busW.sync_bin_out, busW.ptr_upd, busW.gray_err} !== expB) begin
        errors++;
        $display("[TB] FAIL rand_stageB_wr[%0d]: got %h want %h", n,
                 {busW.sync_gray_out, busW.sync_bin_out, busW.ptr_upd, busW.gray_err}, expB);
      end
      if ({busR.sync_gray_out, busR.sync_bin_out, busR.ptr_upd, busR.gray_err} !== expB) begin
        errors++;
        $display("[TB] FAIL rand_stageB_rd[%0d]: got %h want %h", n,
                 {busR.sync_gray_out, busR.sync_bin_out, busR.ptr_upd, busR.gray_err}, expB);
      end
      if ({busW.level, busW.flag, busW.thr_flag, busW.level_err} !== expCW) begin
        errors++;
        $display("[TB] FAIL rand_stageC_wr[%0d]: got %h want %h", n,
                 {busW.level, busW.flag, busW.thr_flag, busW.level_err}, expCW);
      end
      if ({busR.level, busR.flag, busR.thr_flag, busR.level_err} !== expCR) begin
        errors++;
        $display("[TB] FAIL rand_stageC_rd[%0d]: got %h want %h", n,
                 {busR.level, busR.flag, busR.thr_flag, busR.level_err}, expCR);
      end
    end
  endtask

  initial begin
    modelReset();
    #2;
    test_reset();
    test_mode1_steps();
    test_gray_jump();
    test_full();
    test_wrap_err();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
